// File: rtl/ram_7x1_ctrl.sv
// Sweep sequencer, round-robin write arbiter and registered read front-end for
// one ram_7x1 bit table. The RAM powers up undefined, so every entry is rewritten after reset/flush.
module ram_7x1_ctrl #(
   parameter int   DEPTH    = 7,
   parameter int   ADDR_W   = 3,
   parameter logic INIT_VAL = 1'b0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush_req,
   output logic              busy,
   input  logic              wa_valid,
   output logic              wa_ready,
   input  logic [ADDR_W-1:0] wa_addr,
   input  logic              wa_data,
   input  logic              wb_valid,
   output logic              wb_ready,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic              wb_data,
   input  logic              rd_valid,
   output logic              rd_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_resp_valid,
   output logic              rd_resp_data,
   output logic [ADDR_W-1:0] mem_R0_addr,
   output logic              mem_R0_en,
   input  logic              mem_R0_data,
   output logic [ADDR_W-1:0] mem_W0_addr,
   output logic              mem_W0_en,
   output logic              mem_W0_data
);

   typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FLUSH} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);

   state_t            state;
   logic [ADDR_W-1:0] sweep_cnt;
   logic              prio;          // 0: A wins a tie, 1: B wins a tie
   logic              resp_vld_p1;
   logic              resp_data_p1;

   logic              in_run;
   logic              grant_a;
   logic              grant_b;
   logic [ADDR_W-1:0] wr_addr;
   logic              wr_data;
   logic              wr_commit;
   logic              rd_accept;
   logic              rd_data_p0;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return {1'b0, a} < DEPTH_X;
   endfunction

   // Stage 0: arbitration, RAM port drive and read-data selection
   always_comb begin
      in_run    = (state == ST_RUN);
      grant_a   = in_run & wa_valid & (~wb_valid | ~prio);
      grant_b   = in_run & wb_valid & (~wa_valid | prio);
      wr_addr   = grant_b ? wb_addr : wa_addr;
      wr_data   = grant_b ? wb_data : wa_data;
      wr_commit = (grant_a | grant_b) & in_range(wr_addr);
      rd_accept = in_run & rd_valid;

      // A same-cycle write to the read address must win over the stale RAM bit
      if (!in_range(rd_addr))
         rd_data_p0 = INIT_VAL;
      else if (wr_commit && (wr_addr == rd_addr))
         rd_data_p0 = wr_data;
      else
         rd_data_p0 = mem_R0_data;

      if (!in_run) begin
         mem_W0_en   = 1'b1;
         mem_W0_addr = sweep_cnt;
         mem_W0_data = INIT_VAL;
      end else begin
         mem_W0_en   = wr_commit;
         mem_W0_addr = wr_addr;
         mem_W0_data = wr_data;
      end

      busy        = ~in_run;
      wa_ready    = grant_a;
      wb_ready    = grant_b;
      rd_ready    = in_run;
      mem_R0_en   = rd_accept;
      mem_R0_addr = in_run ? rd_addr : '0;
   end

   // Stage 1: control state and registered read response
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= ST_INIT;
         sweep_cnt    <= '0;
         prio         <= 1'b0;
         resp_vld_p1  <= 1'b0;
         resp_data_p1 <= 1'b0;
      end else begin
         case (state)
            ST_INIT, ST_FLUSH: begin
               if (sweep_cnt == LAST_ADDR) begin
                  state     <= ST_RUN;
                  sweep_cnt <= '0;
               end else begin
                  sweep_cnt <= sweep_cnt + ADDR_W'(1);
               end
            end
            ST_RUN: begin
               if (flush_req)
                  state <= ST_FLUSH;
            end
            default: state <= ST_INIT;
         endcase

         if (in_run && wa_valid && wb_valid)
            prio <= ~prio;

         resp_vld_p1 <= rd_accept;
         if (rd_accept)
            resp_data_p1 <= rd_data_p0;
      end
   end

   assign rd_resp_valid = resp_vld_p1;
   assign rd_resp_data  = resp_data_p1;

endmodule

// File: tb/tb_ram_7x1_ctrl.sv
// Bench for ram_7x1_ctrl: behavioural RAM + table-level reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_ram_7x1_ctrl;

   localparam int   DEPTH    = 7;
   localparam int   ADDR_W   = 3;
   localparam logic INIT_VAL = 1'b0;

   logic              clock;
   logic              reset;
   logic              flush_req;
   logic              busy;
   logic              wa_valid, wa_ready, wa_data;
   logic [ADDR_W-1:0] wa_addr;
   logic              wb_valid, wb_ready, wb_data;
   logic [ADDR_W-1:0] wb_addr;
   logic              rd_valid, rd_ready;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_resp_valid, rd_resp_data;
   logic [ADDR_W-1:0] mem_R0_addr, mem_W0_addr;
   logic              mem_R0_en, mem_R0_data, mem_W0_en, mem_W0_data;

   int n_vec  = 0;
   int n_miss = 0;

   ram_7x1_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INIT_VAL(INIT_VAL)) dut (
      .clock(clock), .reset(reset), .flush_req(flush_req), .busy(busy),
      .wa_valid(wa_valid), .wa_ready(wa_ready), .wa_addr(wa_addr), .wa_data(wa_data),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
      .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
      .mem_R0_addr(mem_R0_addr), .mem_R0_en(mem_R0_en), .mem_R0_data(mem_R0_data),
      .mem_W0_addr(mem_W0_addr), .mem_W0_en(mem_W0_en), .mem_W0_data(mem_W0_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Behavioural RAM, powered up to all ones so that a missed sweep write is visible
   logic [7:0] ram = 8'hFF;
   always @(posedge clock)
      if (mem_W0_en) ram[mem_W0_addr] <= mem_W0_data;
   assign mem_R0_data = ram[mem_R0_addr];

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: table contents, sweep cycles remaining, tie-break owner, pending response
   int m_left = DEPTH;
   bit m_prio_b = 1'b0;
   bit m_ref [0:7];
   bit m_rv = 1'b0;
   bit m_rd = 1'b0;
   bit t_ref [0:7];
   bit t_run, t_ga, t_gb;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_left   <= DEPTH;
         m_prio_b <= 1'b0;
         m_rv     <= 1'b0;
         m_rd     <= 1'b0;
      end else begin
         t_ref = m_ref;
         t_run = (m_left == 0);
         t_ga  = t_run && wa_valid && (!wb_valid || !m_prio_b);
         t_gb  = t_run && wb_valid && (!wa_valid || m_prio_b);
         if (t_ga && int'(wa_addr) < DEPTH) t_ref[wa_addr] = wa_data;
         if (t_gb && int'(wb_addr) < DEPTH) t_ref[wb_addr] = wb_data;
         // A read sees the table as it stands after this edge's write
         m_rv <= t_run && rd_valid;
         if (t_run && rd_valid)
            m_rd <= (int'(rd_addr) < DEPTH) ? t_ref[rd_addr] : INIT_VAL;
         if (!t_run) begin
            t_ref[DEPTH - m_left] = INIT_VAL;
            m_left <= m_left - 1;
         end else if (flush_req) begin
            m_left <= DEPTH;
         end
         if (t_run && wa_valid && wb_valid) m_prio_b <= !m_prio_b;
         m_ref <= t_ref;
      end
   end

   bit e_busy, e_ga, e_gb, e_en;
   always @(negedge clock) begin
      e_busy = (m_left != 0);
      e_ga   = !e_busy && wa_valid && (!wb_valid || !m_prio_b);
      e_gb   = !e_busy && wb_valid && (!wa_valid || m_prio_b);
      chk("busy", int'(busy), int'(e_busy));
      chk("wa_ready", int'(wa_ready), int'(e_ga));
      chk("wb_ready", int'(wb_ready), int'(e_gb));
      chk("rd_ready", int'(rd_ready), int'(!e_busy));
      chk("mem_R0_en", int'(mem_R0_en), int'(!e_busy && rd_valid));
      if (!e_busy && rd_valid) chk("mem_R0_addr", int'(mem_R0_addr), int'(rd_addr));
      if (!reset) chk("mem_R0_addr_rst", int'(mem_R0_addr), 0);
      if (e_busy) begin
         chk("sweep_en", int'(mem_W0_en), 1);
         chk("sweep_addr", int'(mem_W0_addr), DEPTH - m_left);
         chk("sweep_data", int'(mem_W0_data), int'(INIT_VAL));
      end else begin
         e_en = (e_ga && int'(wa_addr) < DEPTH) || (e_gb && int'(wb_addr) < DEPTH);
         chk("wr_en", int'(mem_W0_en), int'(e_en));
         if (e_en) begin
            chk("wr_addr", int'(mem_W0_addr), int'(e_gb ? wb_addr : wa_addr));
            chk("wr_data", int'(mem_W0_data), int'(e_gb ? wb_data : wa_data));
         end
      end
      chk("resp_valid", int'(rd_resp_valid), int'(m_rv));
      chk("resp_data", int'(rd_resp_data), int'(m_rd));
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      wa_valid = 0; wb_valid = 0; rd_valid = 0; flush_req = 0;
   endtask

   task automatic sweep_len(output int n);
      n = 0;
      while (busy && n < 40) begin
         step();
         n++;
      end
   endtask

   task automatic read_expect(input int a, input int exp, input string name);
      rd_valid = 1; rd_addr = 3'(a);
      step();
      rd_valid = 0;
      #1;
      chk({name, "_v"}, int'(rd_resp_valid), 1);
      chk(name, int'(rd_resp_data), exp);
   endtask

   int n;

   initial begin
      reset = 1'b1;
      idle();
      wa_addr = 0; wa_data = 0; wb_addr = 0; wb_data = 0; rd_addr = 0;
      #2 reset = 1'b0;
      #1;
      chk("rst_busy", int'(busy), 1);
      chk("rst_w_en", int'(mem_W0_en), 1);
      chk("rst_w_addr", int'(mem_W0_addr), 0);
      chk("rst_rd_ready", int'(rd_ready), 0);
      chk("rst_resp_v", int'(rd_resp_valid), 0);
      repeat (2) step();
      reset = 1'b1;
      sweep_len(n);
      chk("init_sweep_len", n, 7);

      for (int i = 0; i < DEPTH; i++) read_expect(i, 0, "init_read");

      // Contention: grants alternate A,B,A,B then A again (prio now favours B)
      wa_valid = 1; wa_addr = 1; wa_data = 1;
      wb_valid = 1; wb_addr = 2; wb_data = 1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("rr_a", int'(wa_ready), int'(k % 2 == 0));
         chk("rr_b", int'(wb_ready), int'(k % 2 == 1));
         step();
      end
      step();
      wb_valid = 0;
      #1 chk("a_alone", int'(wa_ready), 1);
      step();
      idle();
      read_expect(1, 1, "rr_addr1");
      read_expect(2, 1, "rr_addr2");

      // Write/read bypass on addr 3
      wa_valid = 1; wa_addr = 3; wa_data = 1;
      rd_valid = 1; rd_addr = 3;
      step();
      wa_valid = 0;
      #1 chk("bypass", int'(rd_resp_data), 1);
      step();
      rd_valid = 0;
      #1 chk("after_bypass", int'(rd_resp_data), 1);

      // Fill with ones, then flush with a same-cycle write and read
      for (int i = 0; i < DEPTH; i++) begin
         wa_valid = 1; wa_addr = 3'(i); wa_data = 1;
         step();
      end
      wa_valid = 1; wa_addr = 5; wa_data = 1;
      rd_valid = 1; rd_addr = 4; flush_req = 1;
      step();
      idle();
      #1 chk("preflush_read", int'(rd_resp_data), 1);
      n = 0;
      while (busy && n < 40) begin
         flush_req = (n == 3);
         step();
         n++;
      end
      flush_req = 0;
      chk("flush_len", n, 7);
      for (int i = 0; i < DEPTH; i++) read_expect(i, 0, "flush_read");

      // Out-of-range address
      wa_valid = 1; wa_addr = 7; wa_data = 1;
      rd_valid = 1; rd_addr = 7;
      #1;
      chk("oor_ready", int'(wa_ready), 1);
      chk("oor_w_en", int'(mem_W0_en), 0);
      step();
      idle();
      #1 chk("oor_read", int'(rd_resp_data), int'(INIT_VAL));

      // Reset at sweep_cnt=3 during a flush, with rd_resp_data holding 1
      wa_valid = 1; wa_addr = 4; wa_data = 1;
      rd_valid = 1; rd_addr = 4;
      step();
      idle();
      flush_req = 1;
      step();
      flush_req = 0;
      repeat (3) step();
      chk("mid_flush_addr", int'(mem_W0_addr), 3);
      chk("held_resp", int'(rd_resp_data), 1);
      reset = 1'b0;
      #1;
      chk("mr_busy", int'(busy), 1);
      chk("mr_w_addr", int'(mem_W0_addr), 0);
      chk("mr_resp_data", int'(rd_resp_data), 0);
      repeat (2) step();
      reset = 1'b1;
      sweep_len(n);
      chk("mr_sweep_len", n, 7);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         wa_valid  = 1'($urandom_range(1));
         wa_addr   = 3'($urandom_range(7));
         wa_data   = 1'($urandom_range(1));
         wb_valid  = 1'($urandom_range(1));
         wb_addr   = 3'($urandom_range(7));
         wb_data   = 1'($urandom_range(1));
         rd_valid  = 1'($urandom_range(1));
         rd_addr   = 3'($urandom_range(7));
         flush_req = ($urandom_range(59) == 0);
         step();
      end
      idle();
      repeat (3) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
